// File: rtl/dff_ram_pkg.sv
// Shared types, default parameters and the lane-merge helper for the flip-flop RAM.
// The merge works on a generous fixed width so one function serves every instance size.
package dff_ram_pkg;

   localparam int DEF_WIDTH  = 72;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_LANE_W = 9;

   localparam int MAX_W     = 1024;
   localparam int MAX_LANES = 1024;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } ram_state_e;

   // Bits whose lane has an active-low enable cleared take the new value; the rest keep the old one.
   function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0]     old_word,
                                                   input logic [MAX_W-1:0]     new_word,
                                                   input logic [MAX_LANES-1:0] mask_n,
                                                   input int                   lane_w);
      logic [MAX_W-1:0] res;
      res = old_word;
      for (int b = 0; b < MAX_W; b++) begin
         if (!mask_n[b / lane_w]) res[b] = new_word[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/dff_ram_clr_seq.sv
// Post-reset clear sequencer: walks every word once writing the init value, then parks in READY.
module dff_ram_clr_seq
   import dff_ram_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              init_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   ram_state_e        state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      init_done = 1'b0;
      case (state)
         INIT: begin
            clr_we = 1'b1;
            if (cnt == LAST) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + ADDR_W'(1);
            end
         end
         READY: init_done = 1'b1;
         default: state_nxt = INIT;
      endcase
   end

   assign clr_addr = cnt;

endmodule

// File: rtl/dff_ram_bm.sv
// Parametrised single-port flip-flop RAM with lane write masks, registered read and range checking.
// The storage array is unreset; the clear sequencer fills it with INIT_VAL after every reset.
module dff_ram_bm
   import dff_ram_pkg::*;
#(
   parameter int                 WIDTH         = DEF_WIDTH,
   parameter int                 DEPTH         = DEF_DEPTH,
   parameter int                 LANE_W        = DEF_LANE_W,
   parameter int                 WRITE_THROUGH = 0,
   parameter logic [WIDTH-1:0]   INIT_VAL      = '0,
   localparam int                ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int                NLANE         = WIDTH / LANE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_n,
   input  logic              wr_n,
   input  logic [ADDR_W-1:0] add,
   input  logic [NLANE-1:0]  wmask_n,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   output logic              addr_err,
   output logic              init_done
);

   if (WIDTH % LANE_W != 0) begin : g_bad_lane
      $error("dff_ram_bm: WIDTH (%0d) must be a multiple of LANE_W (%0d)", WIDTH, LANE_W);
   end
   if (WIDTH > MAX_W) begin : g_bad_width
      $error("dff_ram_bm: WIDTH (%0d) exceeds lane_merge capacity (%0d)", WIDTH, MAX_W);
   end

   logic [WIDTH-1:0]  mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              access, in_range, wr_hit;
   logic [WIDTH-1:0]  rd_word, merged;

   dff_ram_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_done (init_done)
   );

   assign access   = init_done && !en_n;
   assign in_range = ({1'b0, add} < (ADDR_W + 1)'(DEPTH));
   assign wr_hit   = access && !wr_n && in_range;
   assign rd_word  = mem[add];
   assign merged   = WIDTH'(lane_merge(MAX_W'(rd_word), MAX_W'(wdata), MAX_LANES'(wmask_n), LANE_W));

   // Clearing owns the array until init_done, so user writes never collide with it.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= INIT_VAL;
      end else if (wr_hit) begin
         mem[add] <= merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata    <= '0;
         rvalid   <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rvalid   <= 1'b0;
         addr_err <= 1'b0;
         if (access) begin
            if (!in_range) begin
               rdata    <= '0;
               addr_err <= 1'b1;
               rvalid   <= wr_n || (WRITE_THROUGH != 0);
            end else if (wr_n) begin
               rdata  <= rd_word;
               rvalid <= 1'b1;
            end else if (WRITE_THROUGH != 0) begin
               rdata  <= merged;
               rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dff_ram_bm.sv
// Scoreboard bench for dff_ram_bm: four instances (base, DEPTH=6, write-through, INIT_VAL=5A)
// share clock and reset; one instance is exercised at a time and a monitor checks every strobe.
module tb_dff_ram_bm;

   typedef struct {
      int          inst;
      int          cyc;
      logic        rv;
      logic        err;
      logic [71:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en_n      [4];
   logic        wr_n      [4];
   logic [2:0]  add_i     [4];
   logic [7:0]  wmask_n   [4];
   logic [71:0] wdata     [4];
   logic [71:0] rdata_o   [4];
   logic        rvalid_o  [4];
   logic        addr_err_o[4];
   logic        init_done_o[4];

   int   cycle;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   localparam logic [71:0] ONES = {72{1'b1}};

   dff_ram_bm #(.WIDTH(72), .DEPTH(8), .LANE_W(9), .WRITE_THROUGH(0), .INIT_VAL(72'h0)) u_base (
      .clk(clk), .rst_n(rst_n), .en_n(en_n[0]), .wr_n(wr_n[0]), .add(add_i[0]),
      .wmask_n(wmask_n[0]), .wdata(wdata[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
      .addr_err(addr_err_o[0]), .init_done(init_done_o[0]));

   dff_ram_bm #(.WIDTH(72), .DEPTH(6), .LANE_W(9), .WRITE_THROUGH(0), .INIT_VAL(72'h0)) u_d6 (
      .clk(clk), .rst_n(rst_n), .en_n(en_n[1]), .wr_n(wr_n[1]), .add(add_i[1]),
      .wmask_n(wmask_n[1]), .wdata(wdata[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
      .addr_err(addr_err_o[1]), .init_done(init_done_o[1]));

   dff_ram_bm #(.WIDTH(72), .DEPTH(8), .LANE_W(9), .WRITE_THROUGH(1), .INIT_VAL(72'h0)) u_wt (
      .clk(clk), .rst_n(rst_n), .en_n(en_n[2]), .wr_n(wr_n[2]), .add(add_i[2]),
      .wmask_n(wmask_n[2]), .wdata(wdata[2]), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]),
      .addr_err(addr_err_o[2]), .init_done(init_done_o[2]));

   dff_ram_bm #(.WIDTH(72), .DEPTH(8), .LANE_W(9), .WRITE_THROUGH(0), .INIT_VAL(72'h5A)) u_iv (
      .clk(clk), .rst_n(rst_n), .en_n(en_n[3]), .wr_n(wr_n[3]), .add(add_i[3]),
      .wmask_n(wmask_n[3]), .wdata(wdata[3]), .rdata(rdata_o[3]), .rvalid(rvalid_o[3]),
      .addr_err(addr_err_o[3]), .init_done(init_done_o[3]));

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Monitor: every strobe must match the oldest expectation, in instance, cycle and content.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_strobe inst=%0d expected at cyc=%0d data=%h, now cyc=%0d",
                  e.inst, e.cyc, e.data, cycle);
      end
      for (int i = 0; i < 4; i++) begin
         if (rvalid_o[i] || addr_err_o[i]) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_strobe inst=%0d cyc=%0d rvalid=%b addr_err=%b rdata=%h, expected no strobe",
                        i, cycle, rvalid_o[i], addr_err_o[i], rdata_o[i]);
            end else begin
               e = exp_q.pop_front();
               if (e.inst != i || e.cyc != cycle || e.rv !== rvalid_o[i] ||
                   e.err !== addr_err_o[i] || e.data !== rdata_o[i]) begin
                  errors++;
                  $display("[TB] FAIL strobe got inst=%0d cyc=%0d rv=%b err=%b data=%h, expected inst=%0d cyc=%0d rv=%b err=%b data=%h",
                           i, cycle, rvalid_o[i], addr_err_o[i], rdata_o[i],
                           e.inst, e.cyc, e.rv, e.err, e.data);
               end
            end
         end
      end
   end

   task automatic expectStrobe(input int i, input logic rv, input logic err, input logic [71:0] d);
      exp_t e;
      e.inst = i;
      e.cyc  = cycle + 1;
      e.rv   = rv;
      e.err  = err;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input int i, input logic wr, input logic [2:0] a,
                                input logic [7:0] m, input logic [71:0] d);
      en_n[i]    = 1'b0;
      wr_n[i]    = wr;
      add_i[i]   = a;
      wmask_n[i] = m;
      wdata[i]   = d;
      @(posedge clk);
      #1;
      en_n[i] = 1'b1;
   endtask

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b0;
      cycle  = 0;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 4; i++) begin
         en_n[i]    = 1'b1;
         wr_n[i]    = 1'b1;
         add_i[i]   = '0;
         wmask_n[i] = '1;
         wdata[i]   = '0;
      end

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("reset_rdata%0d", i), rdata_o[i], 72'h0);
         checkOutput($sformatf("reset_flags%0d", i),
                     72'({rvalid_o[i], addr_err_o[i], init_done_o[i]}), 72'h0);
      end

      // Release reset; the first edge after it is also a read that must be ignored.
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 3'd0, 8'hFF, 72'h0);
      checkOutput("init_busy_edge1", 72'(init_done_o[0]), 72'h0);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("init_busy_edge7", 72'(init_done_o[0]), 72'h0);
      checkOutput("init_done_d6_edge7", 72'(init_done_o[1]), 72'h1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) checkOutput($sformatf("init_done%0d", i), 72'(init_done_o[i]), 72'h1);

      // Cleared contents, back-to-back reads.
      for (int a = 0; a < 8; a++) begin
         expectStrobe(0, 1'b1, 1'b0, 72'h0);
         applyStimulus(0, 1'b1, 3'(a), 8'hFF, 72'h0);
      end
      expectStrobe(3, 1'b1, 1'b0, 72'h5A);
      applyStimulus(3, 1'b1, 3'd0, 8'hFF, 72'h0);

      // Full write then immediate read.
      applyStimulus(0, 1'b0, 3'd3, 8'h00, 72'h1);
      expectStrobe(0, 1'b1, 1'b0, 72'h1);
      applyStimulus(0, 1'b1, 3'd3, 8'hFF, 72'h0);

      // Lane-masked write keeps untouched lanes; rdata holds across a plain write.
      applyStimulus(0, 1'b0, 3'd5, 8'h00, ONES);
      checkOutput("rdata_hold_on_write", rdata_o[0], 72'h1);
      applyStimulus(0, 1'b0, 3'd5, 8'hFE, 72'h0);
      expectStrobe(0, 1'b1, 1'b0, 72'hFF_FFFF_FFFF_FFFF_FE00);
      applyStimulus(0, 1'b1, 3'd5, 8'hFF, 72'h0);

      // All-ones mask is a no-op.
      applyStimulus(0, 1'b0, 3'd3, 8'hFF, ONES);
      expectStrobe(0, 1'b1, 1'b0, 72'h1);
      applyStimulus(0, 1'b1, 3'd3, 8'hFF, 72'h0);

      // DEPTH=6: out-of-range write and read flag errors and leave memory alone.
      applyStimulus(1, 1'b0, 3'd1, 8'h00, 72'h77);
      expectStrobe(1, 1'b0, 1'b1, 72'h0);
      applyStimulus(1, 1'b0, 3'd7, 8'h00, ONES);
      expectStrobe(1, 1'b1, 1'b1, 72'h0);
      applyStimulus(1, 1'b1, 3'd7, 8'hFF, 72'h0);
      expectStrobe(1, 1'b1, 1'b0, 72'h77);
      applyStimulus(1, 1'b1, 3'd1, 8'hFF, 72'h0);
      expectStrobe(1, 1'b1, 1'b1, 72'h0);
      applyStimulus(1, 1'b1, 3'd6, 8'hFF, 72'h0);
      expectStrobe(1, 1'b1, 1'b0, 72'h0);
      applyStimulus(1, 1'b1, 3'd5, 8'hFF, 72'h0);

      // Write-through returns the merged word on the write itself.
      expectStrobe(2, 1'b1, 1'b0, 72'd2);
      applyStimulus(2, 1'b0, 3'd2, 8'h00, 72'd2);
      expectStrobe(2, 1'b1, 1'b0, 72'h1FF);
      applyStimulus(2, 1'b0, 3'd2, 8'hFE, ONES);
      expectStrobe(2, 1'b1, 1'b0, 72'h1FF);
      applyStimulus(2, 1'b1, 3'd2, 8'hFF, 72'h0);

      // Mid-stream reset wipes outputs at once and contents after the clear.
      applyStimulus(0, 1'b0, 3'd4, 8'h00, 72'hABC);
      applyStimulus(3, 1'b0, 3'd4, 8'h00, 72'hABC);
      expectStrobe(0, 1'b1, 1'b0, 72'hABC);
      applyStimulus(0, 1'b1, 3'd4, 8'hFF, 72'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_rdata", rdata_o[0], 72'h0);
      checkOutput("async_rst_flags", 72'({rvalid_o[0], init_done_o[0]}), 72'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("reinit_done0", 72'(init_done_o[0]), 72'h1);
      checkOutput("reinit_done3", 72'(init_done_o[3]), 72'h1);
      expectStrobe(0, 1'b1, 1'b0, 72'h0);
      applyStimulus(0, 1'b1, 3'd4, 8'hFF, 72'h0);
      expectStrobe(3, 1'b1, 1'b0, 72'h5A);
      applyStimulus(3, 1'b1, 3'd4, 8'hFF, 72'h0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 72'(exp_q.size()), 72'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
